// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - staged reset release sequencer with soft-reset and watchdog restart
// Optional watchdog restart is built when RST_SEQ_WDT_EN is defined.
module rst_seq #(
  parameter int N_STAGE   = 4,
  parameter int HOLD_CYC  = 8,
  parameter int STAGE_DLY = 16,
  parameter int CNT_W     = 16,
  parameter int WDT_CYC   = 1000
) (
  input  logic               clk,
  input  logic               asrst,
  input  logic               soft_rst_req,
  input  logic               wdt_kick,
  output logic [N_STAGE-1:0] rst_out,
  output logic               seq_done,
  output logic [1:0]         rst_cause
);

  localparam int IDX_W = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_TC  = CNT_W'(STAGE_DLY - 1);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(N_STAGE - 1);

  typedef enum logic [1:0] {S_HOLD, S_REL, S_RUN} state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [N_STAGE-1:0] rst_n_v;
  logic               done_n;
  logic [1:0]         cause_n;
  logic               wdt_exp;

`ifdef RST_SEQ_WDT_EN
  localparam logic [CNT_W-1:0] WDT_TC = CNT_W'(WDT_CYC - 1);
  // A kick on the terminal edge wins over expiry.
  assign wdt_exp = (state_q == S_RUN) && !wdt_kick && (cnt_q == WDT_TC);
`else
  logic unused_wdt;
  assign unused_wdt = wdt_kick | (WDT_CYC == 0);
  assign wdt_exp    = 1'b0;
`endif

  always_ff @(posedge clk or posedge asrst) begin
    if (asrst) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out   <= '1;
      seq_done  <= 1'b0;
      rst_cause <= 2'b00;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      idx_q     <= idx_n;
      rst_out   <= rst_n_v;
      seq_done  <= done_n;
      rst_cause <= cause_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    rst_n_v = rst_out;
    done_n  = seq_done;
    cause_n = rst_cause;
    if (soft_rst_req || wdt_exp) begin
      // Restart; a held request keeps the counter parked at zero.
      state_n = S_HOLD;
      cnt_n   = '0;
      idx_n   = '0;
      rst_n_v = '1;
      done_n  = 1'b0;
      cause_n = soft_rst_req ? 2'b01 : 2'b10;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_TC) begin
            rst_n_v[0] = 1'b0;
            cnt_n      = '0;
            idx_n      = IDX_W'(1);
            if (N_STAGE == 1) begin
              done_n  = 1'b1;
              state_n = S_RUN;
            end else begin
              state_n = S_REL;
            end
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        S_REL: begin
          if (cnt_q == DLY_TC) begin
            rst_n_v[idx_q] = 1'b0;
            cnt_n          = '0;
            if (idx_q == LAST) begin
              done_n  = 1'b1;
              state_n = S_RUN;
            end else begin
              idx_n = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
`ifdef RST_SEQ_WDT_EN
          if (wdt_kick) begin
            cnt_n = '0;
          end else if (cnt_q != WDT_TC) begin
            cnt_n = cnt_q + CNT_W'(1);
          end
`else
          cnt_n = '0;
`endif
        end
        default: begin
          state_n = S_HOLD;
          cnt_n   = '0;
          idx_n   = '0;
          rst_n_v = '1;
          done_n  = 1'b0;
        end
      endcase
    end
  end

endmodule
